// File: rtl/shift_arbiter_pkg.sv
// Shared widths, op encodings and FSM state type for the shift arbiter and its datapath.
package shift_arbiter_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned ID_W   = 3;

  localparam logic [OP_W-1:0] OP_SLL = 2'b00;
  localparam logic [OP_W-1:0] OP_SRL = 2'b01;
  localparam logic [OP_W-1:0] OP_ROL = 2'b10;
  localparam logic [OP_W-1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result handshake bundle between requesters, consumer and the shift arbiter.
interface shift_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import shift_arbiter_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [AMT_W*NUM_REQ-1:0]  req_amt;
  logic [OP_W*NUM_REQ-1:0]   req_op;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_data;
  logic [ID_W-1:0]           res_id;

  modport master (
    output req_valid, req_data, req_amt, req_op, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_op, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/barrel_shifter_8.sv
// Combinational 8-bit shifter/rotator: each output bit is an 8:1 mux indexed by the amount.
module barrel_shifter_8
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] out
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    logic [DATA_W-1:0] cand;
    for (genvar s = 0; s < DATA_W; s++) begin : g_amt
      localparam int unsigned Left    = (i + DATA_W - s) % DATA_W;
      localparam int unsigned Right   = (i + s) % DATA_W;
      localparam bit          LeftIn  = (i >= s);
      localparam bit          RightIn = ((i + s) < DATA_W);
      // Logical shifts zero the source bit once it falls off the edge.
      assign cand[s] = (op == OP_ROL) ? data[Left]  :
                       (op == OP_ROR) ? data[Right] :
                       (op == OP_SLL) ? (LeftIn & data[Left]) :
                                        (RightIn & data[Right]);
    end
    assign out[i] = cand[amt];
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NUM_REQ requesters (IDLE/EXEC/DONE).
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  bus,
  output logic            busy
);

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [DATA_W-1:0] op_data_q;
  logic [AMT_W-1:0]  op_amt_q;
  logic [OP_W-1:0]   op_op_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic [ID_W-1:0]   res_id_q;

  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic [7:0]        valid_pad;
  logic [3:0]        sum;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] shift_out;

  // First valid requester found scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    valid_pad = 8'(bus.req_valid);
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + 4'(k);
      if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
      if (!grant_any && valid_pad[sum[2:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[2:0];
      end
    end
  end

  always_comb begin
    sel_data      = '0;
    sel_amt       = '0;
    sel_op        = '0;
    bus.req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_idx == ID_W'(j)) begin
        sel_data = bus.req_data[DATA_W*j +: DATA_W];
        sel_amt  = bus.req_amt[AMT_W*j +: AMT_W];
        sel_op   = bus.req_op[OP_W*j +: OP_W];
        bus.req_ready[j] = rst_n && (state_q == StIdle) && grant_any;
      end
    end
  end

  barrel_shifter_8 u_shifter (
    .data (op_data_q),
    .amt  (op_amt_q),
    .op   (op_op_q),
    .out  (shift_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      op_data_q   <= '0;
      op_amt_q    <= '0;
      op_op_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            op_data_q <= sel_data;
            op_amt_q  <= sel_amt;
            op_op_q   <= sel_op;
            res_id_q  <= grant_idx;
            rr_ptr_q  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 3'd1;
            state_q   <= StExec;
          end
        end
        StExec: begin
          res_data_q  <= shift_out;
          res_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign busy          = (state_q != StIdle);

endmodule
